// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester/response bundle between the two ALU clients and the arbiter
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-port sequencer for the shared 8-bit combinational ALU
module alu_arbiter #(
  parameter int ADD_WAIT    = 0,
  parameter int MULDIV_WAIT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic         alu_sub,
  output logic [2:0]   alu_op_select,
  input  logic [7:0]   alu_result
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt;
  logic       owner;
  logic       last_grant;
  logic       gnt;
  logic       any_valid;
  logic       accept;
  logic       sel_err;
  logic [2:0] sel_op;
  logic [7:0] sel_a;
  logic [7:0] sel_b;
  logic [7:0] rsp_result_q;
  logic       rsp_zero_q;
  logic       rsp_err_q;

  // Contention goes to whichever port did not win the previous accept.
  always_comb begin
    any_valid = |bus.req_valid;
    case (bus.req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end

  assign sel_op  = gnt ? bus.req_op[5:3] : bus.req_op[2:0];
  assign sel_a   = gnt ? bus.req_a[15:8] : bus.req_a[7:0];
  assign sel_b   = gnt ? bus.req_b[15:8] : bus.req_b[7:0];
  assign sel_err = (sel_op > 3'd5) || ((sel_op == 3'd5) && (sel_b == 8'h00));

  // Held low while reset is asserted so no grant is shown to requesters.
  assign bus.req_ready = (state == IDLE && rst_n && any_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);

  assign bus.rsp_valid  = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = sel_err ? RESP : EXEC;
      EXEC: if (cnt == 2'd0) state_nxt = RESP;
      RESP: if (bus.rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 2'd0;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      alu_a         <= 8'h00;
      alu_b         <= 8'h00;
      alu_sub       <= 1'b0;
      alu_op_select <= 3'd0;
      rsp_result_q  <= 8'h00;
      rsp_zero_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else if (accept) begin
      owner         <= gnt;
      last_grant    <= gnt;
      alu_a         <= sel_a;
      alu_b         <= sel_b;
      alu_sub       <= (sel_op == 3'd1);
      alu_op_select <= sel_op;
      cnt           <= (sel_op >= 3'd4) ? 2'(MULDIV_WAIT) : 2'(ADD_WAIT);
      if (sel_err) begin
        rsp_result_q <= 8'h00;
        rsp_zero_q   <= 1'b1;
        rsp_err_q    <= 1'b1;
      end
    end else if (state == EXEC) begin
      if (cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end else begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= (alu_result == 8'h00);
        rsp_err_q    <= 1'b0;
      end
    end
  end
endmodule
